// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline definitions for the hazard controller: FSM states and forwarding encodings.
package pipe_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        MWAIT = 2'd1,
        MERR  = 2'd2
    } hz_state_t;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    localparam logic [1:0] SEL_RESULT_LOAD = 2'b01;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline <-> hazard controller signal bundle. The slave modport is the controller side.
// HAZARD_PERF_CNT_EN adds the stall/flush performance counter outputs.
interface hazard_ctrl_if
`ifdef HAZARD_PERF_CNT_EN
    #(parameter int PERF_W = 32)
`endif
    ;
    import pipe_pkg::*;

    logic [4:0] D_rf_a1;
    logic [4:0] D_rf_a2;
    logic [4:0] E_rf_a1;
    logic [4:0] E_rf_a2;
    logic [4:0] E_rf_a3;
    logic [1:0] E_sel_result;
    logic       E_pc_src;
    logic [4:0] M_rf_a3;
    logic       M_we_rf;
    logic       M_dm_req;
    logic       M_dm_ready;
    logic [4:0] W_rf_a3;
    logic       W_we_rf;

    logic       stall_f;
    logic       stall_d;
    logic       flush_d;
    logic       flush_e;
    logic       stall_em;
    logic       flush_w;
    logic [1:0] fwd_a_e;
    logic [1:0] fwd_b_e;
    logic       mem_err;
    hz_state_t  fsm_state;
`ifdef HAZARD_PERF_CNT_EN
    logic [PERF_W-1:0] perf_stall_cnt;
    logic [PERF_W-1:0] perf_flush_cnt;
`endif

    // Controls are level signals evaluated every cycle; there is no valid/ready
    // handshake on this bundle, the pipeline simply applies them at the next edge.
    modport master (
        output D_rf_a1, D_rf_a2, E_rf_a1, E_rf_a2, E_rf_a3, E_sel_result, E_pc_src,
               M_rf_a3, M_we_rf, M_dm_req, M_dm_ready, W_rf_a3, W_we_rf,
        input  stall_f, stall_d, flush_d, flush_e, stall_em, flush_w,
               fwd_a_e, fwd_b_e, mem_err, fsm_state
`ifdef HAZARD_PERF_CNT_EN
        , input perf_stall_cnt, perf_flush_cnt
`endif
    );

    modport slave (
        input  D_rf_a1, D_rf_a2, E_rf_a1, E_rf_a2, E_rf_a3, E_sel_result, E_pc_src,
               M_rf_a3, M_we_rf, M_dm_req, M_dm_ready, W_rf_a3, W_we_rf,
        output stall_f, stall_d, flush_d, flush_e, stall_em, flush_w,
               fwd_a_e, fwd_b_e, mem_err, fsm_state
`ifdef HAZARD_PERF_CNT_EN
        , output perf_stall_cnt, perf_flush_cnt
`endif
    );

endinterface

// File: rtl/hazard_ctrl_fwd_unit.sv
// Combinational forwarding select for one ALU operand; the younger MEM result wins over WB.
module hazard_fwd_unit
    import pipe_pkg::*;
(
    input  logic [4:0] e_rs,
    input  logic [4:0] m_rd,
    input  logic       m_we,
    input  logic [4:0] w_rd,
    input  logic       w_we,
    output logic [1:0] fwd
);

    always_comb begin
        fwd = FWD_RF;
        if (m_we && (m_rd != 5'd0) && (m_rd == e_rs)) begin
            fwd = FWD_MEM;
        end else if (w_we && (w_rd != 5'd0) && (w_rd == e_rs)) begin
            fwd = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller: load-use stall, redirect flush, data-memory wait with timeout, forwarding.
// Optional HAZARD_PERF_CNT_EN adds saturating stall/flush cycle counters.
module hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255,
    parameter int TO_W        = 16
`ifdef HAZARD_PERF_CNT_EN
    , parameter int PERF_W    = 32
`endif
) (
    input  logic           clk,
    input  logic           rst,
    hazard_ctrl_if.slave   hz
);

    localparam logic [TO_W-1:0] TIMEOUT_V = TO_W'(MEM_TIMEOUT);

    hz_state_t       state, state_nxt;
    logic [TO_W-1:0] cnt, cnt_nxt, cnt_inc;
    logic            err_q, err_nxt;

    logic            lu, mw;
    logic [1:0]      fwd_a_raw, fwd_b_raw;

    hazard_fwd_unit u_fwd_a (
        .e_rs (hz.E_rf_a1),
        .m_rd (hz.M_rf_a3),
        .m_we (hz.M_we_rf),
        .w_rd (hz.W_rf_a3),
        .w_we (hz.W_we_rf),
        .fwd  (fwd_a_raw)
    );

    hazard_fwd_unit u_fwd_b (
        .e_rs (hz.E_rf_a2),
        .m_rd (hz.M_rf_a3),
        .m_we (hz.M_we_rf),
        .w_rd (hz.W_rf_a3),
        .w_we (hz.W_we_rf),
        .fwd  (fwd_b_raw)
    );

    assign lu = (hz.E_sel_result == SEL_RESULT_LOAD) && (hz.E_rf_a3 != 5'd0) &&
                ((hz.E_rf_a3 == hz.D_rf_a1) || (hz.E_rf_a3 == hz.D_rf_a2));
    assign mw = hz.M_dm_req && !hz.M_dm_ready;
    assign cnt_inc = cnt + TO_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
            cnt   <= '0;
            err_q <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            err_q <= err_nxt;
        end
    end

    // The counter holds the number of wait cycles seen so far, including the
    // RUN cycle that first saw the stall.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        err_nxt   = err_q;
        case (state)
            RUN: begin
                if (mw) begin
                    state_nxt = MWAIT;
                    cnt_nxt   = TO_W'(1);
                end
            end
            MWAIT: begin
                if (hz.M_dm_ready) begin
                    state_nxt = RUN;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt_inc;
                    if (cnt_inc >= TIMEOUT_V) begin
                        state_nxt = MERR;
                        err_nxt   = 1'b1;
                    end
                end
            end
            MERR: begin
                state_nxt = MERR;
                err_nxt   = 1'b1;
            end
            default: begin
                state_nxt = RUN;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        hz.stall_f   = 1'b0;
        hz.stall_d   = 1'b0;
        hz.flush_d   = 1'b0;
        hz.flush_e   = 1'b0;
        hz.stall_em  = 1'b0;
        hz.flush_w   = 1'b0;
        hz.fwd_a_e   = FWD_RF;
        hz.fwd_b_e   = FWD_RF;
        hz.mem_err   = 1'b0;
        hz.fsm_state = RUN;
        if (!rst) begin
            hz.fwd_a_e   = fwd_a_raw;
            hz.fwd_b_e   = fwd_b_raw;
            hz.mem_err   = err_q;
            hz.fsm_state = state;
            case (state)
                RUN: begin
                    if (mw) begin
                        hz.stall_f  = 1'b1;
                        hz.stall_d  = 1'b1;
                        hz.stall_em = 1'b1;
                        hz.flush_w  = 1'b1;
                    end else if (hz.E_pc_src) begin
                        // A simultaneous load-use is moot: the dependent instruction is flushed.
                        hz.flush_d = 1'b1;
                        hz.flush_e = 1'b1;
                    end else if (lu) begin
                        hz.stall_f = 1'b1;
                        hz.stall_d = 1'b1;
                        hz.flush_e = 1'b1;
                    end
                end
                MWAIT: begin
                    if (!hz.M_dm_ready) begin
                        hz.stall_f  = 1'b1;
                        hz.stall_d  = 1'b1;
                        hz.stall_em = 1'b1;
                        hz.flush_w  = 1'b1;
                    end
                end
                MERR: begin
                    hz.stall_f  = 1'b1;
                    hz.stall_d  = 1'b1;
                    hz.stall_em = 1'b1;
                    hz.flush_w  = 1'b1;
                end
                default: begin
                    hz.stall_f = 1'b0;
                end
            endcase
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [PERF_W-1:0] stall_cnt_q, flush_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (hz.stall_f && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + PERF_W'(1);
            end
            if (hz.flush_d && (flush_cnt_q != '1)) begin
                flush_cnt_q <= flush_cnt_q + PERF_W'(1);
            end
        end
    end

    assign hz.perf_stall_cnt = rst ? '0 : stall_cnt_q;
    assign hz.perf_flush_cnt = rst ? '0 : flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl with MEM_TIMEOUT=4; expected control
// vectors are queued as stimulus is driven and compared on the falling edge.
module tb_hazard_ctrl;
    import pipe_pkg::*;

    localparam int W = 13;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    logic [W-1:0] exp_q[$];

    hazard_ctrl_if hif ();

    hazard_ctrl #(.MEM_TIMEOUT(4), .TO_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .hz  (hif.slave)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {state, stall_f, stall_d, flush_d, flush_e, stall_em, flush_w, fwd_a, fwd_b, mem_err}
    function automatic logic [W-1:0] mk(input logic [1:0] st, input logic sf, input logic sd,
                                        input logic fd, input logic fe, input logic sem,
                                        input logic fw, input logic [1:0] fa,
                                        input logic [1:0] fb, input logic me);
        return {st, sf, sd, fd, fe, sem, fw, fa, fb, me};
    endfunction

    function automatic logic [W-1:0] observed();
        return {hif.fsm_state, hif.stall_f, hif.stall_d, hif.flush_d, hif.flush_e,
                hif.stall_em, hif.flush_w, hif.fwd_a_e, hif.fwd_b_e, hif.mem_err};
    endfunction

    task automatic clear_inputs();
        hif.D_rf_a1 = 5'd0;  hif.D_rf_a2 = 5'd0;
        hif.E_rf_a1 = 5'd0;  hif.E_rf_a2 = 5'd0;  hif.E_rf_a3 = 5'd0;
        hif.E_sel_result = 2'b00;  hif.E_pc_src = 1'b0;
        hif.M_rf_a3 = 5'd0;  hif.M_we_rf = 1'b0;
        hif.M_dm_req = 1'b0; hif.M_dm_ready = 1'b0;
        hif.W_rf_a3 = 5'd0;  hif.W_we_rf = 1'b0;
    endtask

    // Queue the expectation for the inputs just driven, compare at negedge, then
    // advance to just after the next rising edge for the following step.
    task automatic expect_step(input string tag, input logic [W-1:0] e);
        logic [W-1:0] obs;
        logic [W-1:0] want;
        exp_q.push_back(e);
        @(negedge clk);
        obs  = observed();
        want = exp_q.pop_front();
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, want);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic random_regs_no_match();
        // operand numbers chosen disjoint from the destination registers used below
        hif.D_rf_a1 = 5'($urandom_range(20, 31));
        hif.D_rf_a2 = 5'($urandom_range(20, 31));
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        // reset with hazards present on the inputs: everything must stay low
        hif.M_dm_req = 1'b1;
        hif.E_rf_a1 = 5'd5; hif.M_rf_a3 = 5'd5; hif.M_we_rf = 1'b1;
        hif.E_pc_src = 1'b1;
        @(posedge clk); #1;
        expect_step("reset_outputs", mk(RUN, 0,0,0,0,0,0, 2'b00, 2'b00, 0));
`ifdef HAZARD_PERF_CNT_EN
        checks++;
        assert (hif.perf_stall_cnt === '0 && hif.perf_flush_cnt === '0) else begin
            errors++;
            $error("FAIL perf_reset: observed %0d/%0d expected 0/0",
                   hif.perf_stall_cnt, hif.perf_flush_cnt);
        end
`endif
        rst = 1'b0;
        clear_inputs();

        // forwarding priority
        random_regs_no_match();
        hif.E_rf_a1 = 5'd5; hif.E_rf_a2 = 5'd3;
        hif.M_rf_a3 = 5'd5; hif.M_we_rf = 1'b1;
        hif.W_rf_a3 = 5'd5; hif.W_we_rf = 1'b1;
        expect_step("fwd_mem_over_wb", mk(RUN, 0,0,0,0,0,0, 2'b10, 2'b00, 0));
        hif.M_we_rf = 1'b0;
        expect_step("fwd_wb", mk(RUN, 0,0,0,0,0,0, 2'b01, 2'b00, 0));
        hif.E_rf_a1 = 5'd0; hif.M_rf_a3 = 5'd0; hif.W_rf_a3 = 5'd0; hif.M_we_rf = 1'b1;
        expect_step("fwd_x0_none", mk(RUN, 0,0,0,0,0,0, 2'b00, 2'b00, 0));
        hif.E_rf_a2 = 5'd9; hif.W_rf_a3 = 5'd9; hif.M_rf_a3 = 5'd4;
        expect_step("fwd_b_wb", mk(RUN, 0,0,0,0,0,0, 2'b00, 2'b01, 0));
        clear_inputs();

        // load-use: one-cycle stall, then MEM forwarding covers it
        hif.E_sel_result = SEL_RESULT_LOAD; hif.E_rf_a3 = 5'd7; hif.D_rf_a2 = 5'd7;
        expect_step("load_use_stall", mk(RUN, 1,1,0,1,0,0, 2'b00, 2'b00, 0));
        clear_inputs();
        hif.E_rf_a2 = 5'd7; hif.M_rf_a3 = 5'd7; hif.M_we_rf = 1'b1;
        expect_step("load_use_after", mk(RUN, 0,0,0,0,0,0, 2'b00, 2'b10, 0));
        clear_inputs();
        hif.E_sel_result = SEL_RESULT_LOAD; hif.E_rf_a3 = 5'd0; hif.D_rf_a1 = 5'd0;
        expect_step("load_use_x0", mk(RUN, 0,0,0,0,0,0, 2'b00, 2'b00, 0));
        hif.E_rf_a3 = 5'd12; hif.D_rf_a1 = 5'd12;
        expect_step("load_use_rs1", mk(RUN, 1,1,0,1,0,0, 2'b00, 2'b00, 0));

        // redirect wins over load-use
        hif.E_pc_src = 1'b1;
        expect_step("redirect_lu", mk(RUN, 0,0,1,1,0,0, 2'b00, 2'b00, 0));
        clear_inputs();

        // memory wait: 3 stalled cycles, then completion
        hif.M_dm_req = 1'b1;
        expect_step("mwait_first", mk(RUN, 1,1,0,0,1,1, 2'b00, 2'b00, 0));
        hif.E_pc_src = 1'b1;
        hif.E_rf_a1 = 5'd6; hif.M_rf_a3 = 5'd6; hif.M_we_rf = 1'b1;
        expect_step("mwait_pc_src_frozen", mk(MWAIT, 1,1,0,0,1,1, 2'b10, 2'b00, 0));
        hif.E_sel_result = SEL_RESULT_LOAD; hif.E_rf_a3 = 5'd8; hif.D_rf_a1 = 5'd8;
        expect_step("mwait_third", mk(MWAIT, 1,1,0,0,1,1, 2'b10, 2'b00, 0));
        clear_inputs();
        hif.M_dm_req = 1'b1; hif.M_dm_ready = 1'b1;
        expect_step("mwait_ready", mk(MWAIT, 0,0,0,0,0,0, 2'b00, 2'b00, 0));
        clear_inputs();
        expect_step("mwait_back_run", mk(RUN, 0,0,0,0,0,0, 2'b00, 2'b00, 0));
        hif.M_dm_ready = 1'b1;
        expect_step("ready_without_req", mk(RUN, 0,0,0,0,0,0, 2'b00, 2'b00, 0));
        clear_inputs();

        // timeout after 4 wait cycles, sticky until reset
        hif.M_dm_req = 1'b1;
        expect_step("to_wait1", mk(RUN,   1,1,0,0,1,1, 2'b00, 2'b00, 0));
        expect_step("to_wait2", mk(MWAIT, 1,1,0,0,1,1, 2'b00, 2'b00, 0));
        expect_step("to_wait3", mk(MWAIT, 1,1,0,0,1,1, 2'b00, 2'b00, 0));
        expect_step("to_wait4", mk(MWAIT, 1,1,0,0,1,1, 2'b00, 2'b00, 0));
        expect_step("to_merr",  mk(MERR,  1,1,0,0,1,1, 2'b00, 2'b00, 1));
        hif.M_dm_ready = 1'b1; hif.E_pc_src = 1'b1;
        expect_step("merr_ready_ignored", mk(MERR, 1,1,0,0,1,1, 2'b00, 2'b00, 1));
        clear_inputs();
        expect_step("merr_sticky", mk(MERR, 1,1,0,0,1,1, 2'b00, 2'b00, 1));
        rst = 1'b1;
        expect_step("merr_rst_high", mk(RUN, 0,0,0,0,0,0, 2'b00, 2'b00, 0));
        rst = 1'b0;
        expect_step("merr_after_rst", mk(RUN, 0,0,0,0,0,0, 2'b00, 2'b00, 0));

        // reset in the middle of a wait, then a full timeout proves the counter cleared
        hif.M_dm_req = 1'b1;
        expect_step("mid_wait1", mk(RUN,   1,1,0,0,1,1, 2'b00, 2'b00, 0));
        expect_step("mid_wait2", mk(MWAIT, 1,1,0,0,1,1, 2'b00, 2'b00, 0));
        rst = 1'b1;
        expect_step("mid_rst_high", mk(RUN, 0,0,0,0,0,0, 2'b00, 2'b00, 0));
        rst = 1'b0;
        hif.M_dm_req = 1'b0;
        expect_step("mid_after_rst", mk(RUN, 0,0,0,0,0,0, 2'b00, 2'b00, 0));
`ifdef HAZARD_PERF_CNT_EN
        checks++;
        assert (hif.perf_stall_cnt === '0 && hif.perf_flush_cnt === '0) else begin
            errors++;
            $error("FAIL perf_after_rst: observed %0d/%0d expected 0/0",
                   hif.perf_stall_cnt, hif.perf_flush_cnt);
        end
`endif
        hif.M_dm_req = 1'b1;
        expect_step("cnt_clr_wait1", mk(RUN,   1,1,0,0,1,1, 2'b00, 2'b00, 0));
        expect_step("cnt_clr_wait2", mk(MWAIT, 1,1,0,0,1,1, 2'b00, 2'b00, 0));
        expect_step("cnt_clr_wait3", mk(MWAIT, 1,1,0,0,1,1, 2'b00, 2'b00, 0));
        expect_step("cnt_clr_wait4", mk(MWAIT, 1,1,0,0,1,1, 2'b00, 2'b00, 0));
        expect_step("cnt_clr_merr",  mk(MERR,  1,1,0,0,1,1, 2'b00, 2'b00, 1));

        // final report
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Pipeline hazard and sequencing controller for the 5-stage core. It generates stall, flush and forwarding-select controls for the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. Its flush_e output drives the ID/EX register clear input. It handles load-use stalls, branch/jump redirects, and data-memory wait states, with a timeout FSM.

Parameters:
MEM_TIMEOUT, 255, max consecutive MEM wait cycles before the error is flagged (1..65535)
TO_W, 16, width of the wait counter; must satisfy 2^TO_W > MEM_TIMEOUT
PERF_W, 32, width of the performance counters (optional feature only)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
D_rf_a1  in  5  rs1 of instruction in ID
D_rf_a2  in  5  rs2 of instruction in ID
E_rf_a1  in  5  rs1 in EX
E_rf_a2  in  5  rs2 in EX
E_rf_a3  in  5  rd in EX
E_sel_result  in  2  result select in EX; 2'b01 = load
E_pc_src  in  1  branch taken or jump resolved in EX
M_rf_a3  in  5  rd in MEM
M_we_rf  in  1  reg write enable in MEM
M_dm_req  in  1  data-memory access active in MEM
M_dm_ready  in  1  data memory completes access this cycle
W_rf_a3  in  5  rd in WB
W_we_rf  in  1  reg write enable in WB
stall_f  out  1  hold PC
stall_d  out  1  hold IF/ID
flush_d  out  1  clear IF/ID
flush_e  out  1  clear ID/EX (bubble)
stall_em  out  1  hold ID/EX and EX/MEM
flush_w  out  1  clear MEM/WB (bubble)
fwd_a_e  out  2  ALU A select: 00 rf, 10 MEM result, 01 WB result
fwd_b_e  out  2  ALU B select, same encoding
mem_err  out  1  sticky memory-timeout error

Behaviour:
- FSM states: RUN, MWAIT, MERR. Reset → RUN, wait counter 0, mem_err 0.
- While rst is high, all outputs are 0.
- Forwarding is combinational in every state, including MWAIT:
  - fwd_a_e = 10 if M_we_rf && M_rf_a3!=0 && M_rf_a3==E_rf_a1.
  - Otherwise 01 if W_we_rf && W_rf_a3!=0 && W_rf_a3==E_rf_a1.
  - Otherwise 00. MEM beats WB. fwd_b_e is identical using E_rf_a2.
- lu (load-use) = E_sel_result==01 && E_rf_a3!=0 && (E_rf_a3==D_rf_a1 || E_rf_a3==D_rf_a2).
- mw (memory wait) = M_dm_req && !M_dm_ready.
- RUN, priority mw > E_pc_src > lu:
  - mw: stall_f, stall_d, stall_em, flush_w = 1. Next state MWAIT; counter ← 1.
  - E_pc_src: flush_d = flush_e = 1, no stall. A concurrent lu is dropped because the dependent instruction is flushed.
  - lu: stall_f = stall_d = flush_e = 1, for exactly one cycle. The load then reaches MEM, lu clears, and MEM forwarding covers the dependency.
- MWAIT:
  - Outputs are as for mw. E_pc_src and lu are ignored (frozen).
  - M_dm_ready=1: outputs deasserted that cycle, which is the completion cycle. Next state RUN; counter ← 0.
  - Otherwise, counter increments. When counter==MEM_TIMEOUT and not ready: next state MERR, mem_err ← 1.
- MERR:
  - stall_f = stall_d = stall_em = flush_w = 1 permanently.
  - mem_err stays 1. Exit only by rst.
- M_dm_ready=1 with M_dm_req=0 is ignored.
- Reset mid-MWAIT returns to RUN on the next edge, with the counter cleared.
- Outputs are combinational from state and inputs. Only the state, counter and mem_err are registered. Zero-cycle latency.

Optional Feature:
- Macro HAZARD_PERF_CNT_EN.
- Defined: adds outputs perf_stall_cnt [PERF_W] and perf_flush_cnt [PERF_W].
  - perf_stall_cnt increments every cycle stall_f=1.
  - perf_flush_cnt increments every cycle flush_d=1.
  - Both saturate at all-ones and clear on rst.
- Undefined: ports and logic absent; behaviour otherwise identical.

Decomposition:
- Shared package pipe_pkg holds:
  - state enum (RUN, MWAIT, MERR)
  - FWD_RF / FWD_WB / FWD_MEM encodings
  - SEL_RESULT_LOAD = 2'b01
- One sub-module, hazard_fwd_unit: the combinational forwarding compare, instantiated once per ALU operand.
- The FSM and counters stay in the top module.

Test Plan:
- Forwarding: E_rf_a1=5, M_rf_a3=5, M_we_rf=1, W_rf_a3=5, W_we_rf=1 → fwd_a_e=10. Drop M_we_rf → 01. Set all rd=0 → 00.
- Load-use: E_sel_result=01, E_rf_a3=7, D_rf_a2=7 → stall_f=stall_d=flush_e=1 for one cycle. Next cycle, with rd moved to MEM, all stalls 0 and fwd_b_e=10.
- Redirect plus load-use in the same cycle: E_pc_src=1, lu true → flush_d=flush_e=1, stall_f=0.
- Memory wait: M_dm_req=1, ready low for 3 cycles, then high → stalls and flush_w held 3 cycles, deasserted on the ready cycle, state back to RUN. A concurrent E_pc_src during the wait gives no flush.
- Timeout: MEM_TIMEOUT=4, ready never asserted → mem_err=1 after 4 wait cycles and stays 1. Stalls persist until rst. rst clears everything the next edge.
- Reset mid-MWAIT after 2 wait cycles → all outputs 0 while rst is high. With HAZARD_PERF_CNT_EN, the counters read 0 after reset.
